// File: rtl/debounce_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// debounce_scheduler_pkg
//   Shared definitions for the debounce scheduler:
//     - state_e  : scan FSM state encodings (S_IDLE, S_SCAN)
//     - CNT_W    : width of each per-channel stability counter
//     - clog2()  : constant function sizing the channel index (min width 1)
// -----------------------------------------------------------------------------
package debounce_scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Picks the first asserted request at or
//   after ptr, searching upward and wrapping past N-1 back to 0.
// Ports
//   req     in  N     request vector (one bit per channel)
//   ptr     in  ID_W  search start index
//   gnt_id  out ID_W  index of the granted request (0 when none)
//   any     out 1     at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick
  import debounce_scheduler_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    int idx;
    idx    = 0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scheduler
//   Shares one debounce integrator across N_BTN raw buttons. Every sample tick
//   the scan FSM visits each channel once; a channel's stable level flips after
//   STABLE_CNT consecutive samples that disagree with it. Flips become pending
//   events that a round-robin arbiter hands out one at a time.
//
//   Optional feature macro: RELEASE_EVT_EN
//     defined   : press and release flips both produce events
//     undefined : only 0->1 flips produce events (evt_press always 1);
//                 btn_level still follows releases
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous active-high reset
//   btn_in     in   N_BTN   raw asynchronous button pins
//   btn_level  out  N_BTN   debounced stable levels
//   evt_valid  out  1       event available
//   evt_ready  in   1       consumer ready
//   evt_id     out  ID_W    channel index of the presented event
//   evt_press  out  1       1 = 0->1 flip, 0 = 1->0 flip
//   evt_lost   out  1       sticky: a pending event was overwritten
//   dbg_state  out  1       scan FSM state (0 = S_IDLE, 1 = S_SCAN)
//
// Event handshake: an event transfers on every clk edge where evt_valid and
// evt_ready are both 1. Once evt_valid is 1 it stays 1 with evt_id/evt_press
// unchanged until that transfer; the register reloads whenever it is empty
// or being drained, so back-to-back transfers run at one event per cycle.
// -----------------------------------------------------------------------------
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BTN-1:0]          btn_in,
  output logic [N_BTN-1:0]          btn_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [clog2(N_BTN)-1:0]   evt_id,
  output logic                      evt_press,
  output logic                      evt_lost,
  output logic                      dbg_state
);

  localparam int ID_W  = clog2(N_BTN);
  localparam int DIV_W = clog2(TICK_DIV);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q;
  state_e           state_q;
  logic [ID_W-1:0]  ch_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pend_q, pend_d, pend_set, pend_clr;
  logic [N_BTN-1:0] dir_q, dir_d;
  logic             lost_q, lost_d;
  logic [ID_W-1:0]  rr_q, rr_next;
  logic             valid_q, press_q;
  logic [ID_W-1:0]  id_q;

  logic             tick, load, any, flip_evt;
  logic [ID_W-1:0]  gnt_id;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));
  assign load = !valid_q || evt_ready;

  rr_pick #(.N(N_BTN), .ID_W(ID_W)) u_rr_pick (
    .req    (pend_q),
    .ptr    (rr_q),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign rr_next = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    pend_clr = '0;
    if (load && any) pend_clr[gnt_id] = 1'b1;
  end

  // Integrator for the channel under scan.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    dir_d    = dir_q;
    pend_set = '0;
    lost_d   = lost_q;
    flip_evt = 1'b0;
    if (state_q == S_SCAN) begin
      if (sync2_q[ch_q] == level_q[ch_q]) begin
        cnt_d[ch_q] = '0;
      end else if (cnt_q[ch_q] == CNT_W'(STABLE_CNT - 1)) begin
        cnt_d[ch_q]   = '0;
        level_d[ch_q] = ~level_q[ch_q];
`ifdef RELEASE_EVT_EN
        flip_evt = 1'b1;
`else
        flip_evt = ~level_q[ch_q];
`endif
        if (flip_evt) begin
          pend_set[ch_q] = 1'b1;
          dir_d[ch_q]    = ~level_q[ch_q];
          // An event being loaded into the output this cycle is not lost.
          if (pend_q[ch_q] && !pend_clr[ch_q]) lost_d = 1'b1;
        end
      end else begin
        cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
      end
    end
  end

  // Set wins over clear so a flip coinciding with a grant stays pending.
  assign pend_d = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      state_q <= S_IDLE;
      ch_q    <= '0;
      cnt_q   <= '{default: '0};
      level_q <= '0;
      pend_q  <= '0;
      dir_q   <= '0;
      lost_q  <= 1'b0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            ch_q    <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (ch_q == ID_W'(N_BTN - 1)) state_q <= S_IDLE;
          else                          ch_q    <= ch_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      lost_q  <= lost_d;
      if (load) begin
        valid_q <= any;
        if (any) begin
          id_q    <= gnt_id;
          press_q <= dir_q[gnt_id];
          rr_q    <= rr_next;
        end
      end
    end
  end

  assign btn_level = level_q;
  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_press = press_q;
  assign evt_lost  = lost_q;
  assign dbg_state = (state_q == S_SCAN);

endmodule

// File: tb/tb_debounce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_debounce_scheduler
//   Bench for debounce_scheduler with N_BTN=4, TICK_DIV=8, STABLE_CNT=3.
//   Level sequences come from a vector table; events are predicted from the
//   expected level changes and matched in order against handshakes.
// -----------------------------------------------------------------------------
module tb_debounce_scheduler;

  localparam int N_BTN = 4;
  localparam int TDIV  = 8;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_press;
  logic       evt_lost;
  logic       dbg_state;

  int checks;
  int errors;

  logic [2:0] exp_q[$];   // {id, press}

  typedef struct {
    logic [3:0] btn;
    int         ticks;
    logic [3:0] exp_level;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

`ifdef RELEASE_EVT_EN
  localparam logic LOST_PRESS = 1'b0;
`else
  localparam logic LOST_PRESS = 1'b1;
`endif

  debounce_scheduler #(
    .N_BTN      (N_BTN),
    .TICK_DIV   (TDIV),
    .STABLE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_press (evt_press),
    .evt_lost  (evt_lost),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] b, input int ticks);
    btn_in = b;
    repeat (ticks * TDIV) @(posedge clk);
    #1;
  endtask

  task automatic push_edges(input logic [3:0] from, input logic [3:0] to);
    for (int i = 0; i < N_BTN; i++) begin
      if (!from[i] && to[i]) exp_q.push_back({2'(i), 1'b1});
`ifdef RELEASE_EVT_EN
      if (from[i] && !to[i]) exp_q.push_back({2'(i), 1'b0});
`endif
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_dbg(input logic want, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (dbg_state !== want && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(dbg_state), 32'(want));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       prev_stall;
  logic [1:0] prev_id;
  logic       prev_press;
  logic [2:0] exp_e;

  initial prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== prev_id || evt_press !== prev_press) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b id=%0d press=%0b, expected valid=1 id=%0d press=%0b",
                   evt_valid, evt_id, evt_press, prev_id, prev_press);
        end
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected: got id=%0d press=%0b, expected no event", evt_id, evt_press);
        end else begin
          exp_e = exp_q.pop_front();
          if ({evt_id, evt_press} !== exp_e) begin
            errors++;
            $display("FAIL evt_order: got id=%0d press=%0b, expected id=%0d press=%0b",
                     evt_id, evt_press, exp_e[2:1], exp_e[0]);
          end
        end
      end
      prev_stall = (evt_valid === 1'b1) && (evt_ready === 1'b0);
      prev_id    = evt_id;
      prev_press = evt_press;
    end
  end

  // ---------------- main sequence ----------------
  logic [3:0] lvl;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    btn_in    = 4'b0000;
    evt_ready = 1'b1;

    // stable presses/releases, bounces, and a 2-sample glitch on ch1
    tbl[0]  = '{btn: 4'b0100, ticks: 5, exp_level: 4'b0100};
    tbl[1]  = '{btn: 4'b0110, ticks: 1, exp_level: 4'b0100};
    tbl[2]  = '{btn: 4'b0100, ticks: 1, exp_level: 4'b0100};
    tbl[3]  = '{btn: 4'b0110, ticks: 1, exp_level: 4'b0100};
    tbl[4]  = '{btn: 4'b0100, ticks: 1, exp_level: 4'b0100};
    tbl[5]  = '{btn: 4'b0110, ticks: 2, exp_level: 4'b0100};
    tbl[6]  = '{btn: 4'b0100, ticks: 1, exp_level: 4'b0100};
    tbl[7]  = '{btn: 4'b0110, ticks: 5, exp_level: 4'b0110};
    tbl[8]  = '{btn: 4'b0010, ticks: 5, exp_level: 4'b0010};
    tbl[9]  = '{btn: 4'b0000, ticks: 5, exp_level: 4'b0000};
    tbl[10] = '{btn: 4'b1001, ticks: 5, exp_level: 4'b1001};
    tbl[11] = '{btn: 4'b0000, ticks: 5, exp_level: 4'b0000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id",    32'(evt_id),    32'd0);
    chk("rst_press", 32'(evt_press), 32'd0);
    chk("rst_lost",  32'(evt_lost),  32'd0);

    // idle inputs: nothing may happen
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("quiet_valid", 32'(evt_valid), 32'd0);
      chk("quiet_level", 32'(btn_level), 32'd0);
    end

    // table-driven level sequences with ready held high
    lvl = 4'b0000;
    for (int i = 0; i < NV; i++) begin
      push_edges(lvl, tbl[i].exp_level);
      hold(tbl[i].btn, tbl[i].ticks);
      @(negedge clk);
      chk($sformatf("level_step%0d", i), 32'(btn_level), 32'(tbl[i].exp_level));
      lvl = tbl[i].exp_level;
    end
    chk("table_drain", 32'(exp_q.size()), 32'd0);
    chk("table_lost",  32'(evt_lost), 32'd0);

    // round-robin: id2 stalls in the output, then ch0+ch3 arrive together;
    // search resumes after id2, so id3 must precede id0
    evt_ready = 1'b0;
    hold(4'b0100, 5);
    chk("rr_first_valid", 32'(evt_valid), 32'd1);
    chk("rr_first_id",    32'(evt_id),    32'd2);
    chk("rr_first_press", 32'(evt_press), 32'd1);
    hold(4'b1101, 5);
    chk("rr_level", 32'(btn_level), 32'hD);
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    exp_q.push_back({2'd0, 1'b1});
    evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rr_drain", 32'(exp_q.size()), 32'd0);
    push_edges(4'b1101, 4'b0000);
    hold(4'b0000, 5);
    chk("rr_release_level", 32'(btn_level), 32'd0);

    // overwrite of a pending event while the output is stalled on id2
    chk("lost_before", 32'(evt_lost), 32'd0);
    evt_ready = 1'b0;
    hold(4'b0100, 5);
    hold(4'b0110, 5);
    hold(4'b0100, 5);
    hold(4'b0110, 5);
    hold(4'b0100, 5);
    chk("lost_set",   32'(evt_lost),  32'd1);
    chk("lost_level", 32'(btn_level), 32'h4);
    exp_q.push_back({2'd2, 1'b1});
    exp_q.push_back({2'd1, LOST_PRESS});
    evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("lost_drain",  32'(exp_q.size()), 32'd0);
    chk("lost_sticky", 32'(evt_lost), 32'd1);
    push_edges(4'b0100, 4'b0000);
    hold(4'b0000, 5);

    // reset in the middle of a scan with an event stalled in the output
    evt_ready = 1'b0;
    btn_in    = 4'b0001;
    wait_valid("pre_rst_valid");
    btn_in = 4'b1001;
    repeat (12) @(posedge clk);
    #1;
    wait_dbg(1'b0, "pre_rst_idle");
    wait_dbg(1'b1, "pre_rst_scan");
    chk("pre_rst_evt", 32'(evt_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", 32'(btn_level), 32'd0);
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_id",    32'(evt_id),    32'd0);
    chk("mid_rst_press", 32'(evt_press), 32'd0);
    chk("mid_rst_lost",  32'(evt_lost),  32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    evt_ready = 1'b1;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd3, 1'b1});
    // first sample lands on the tick 8 cycles after reset; three are needed
    repeat (20) @(negedge clk);
    chk("post_rst_no_early_flip", 32'(btn_level), 32'd0);
    repeat (20) @(negedge clk);
    chk("post_rst_level", 32'(btn_level), 32'h9);
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

    push_edges(4'b1001, 4'b0000);
    hold(4'b0000, 5);
    repeat (10) @(posedge clk);
    #1;
    chk("final_level", 32'(btn_level), 32'd0);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
